// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
// Log2(WIDTH)-stage barrel shifter with logical, arithmetic and rotate modes
// in both directions. Stage k applies the 2^k component of the shift amount.
// One global advance signal moves the whole pipeline, so results leave in
// issue order and stay frozen while downstream back-pressures.
// Optional feature macro: PBS_FLAGS_EN adds the out_zero / out_carry flags
// together with their pipeline registers.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef PBS_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    // Per-stage pipeline registers and their next-state values
    logic             valid_r   [SHW];
    logic [WIDTH-1:0] data_r    [SHW];
    logic             dir_r     [SHW];
    logic [1:0]       mode_r    [SHW];
    logic [SHW-1:0]   shift_r   [SHW];
    logic             valid_s   [SHW];
    logic [WIDTH-1:0] data_s    [SHW];
    logic             dir_s     [SHW];
    logic [1:0]       mode_s    [SHW];
    logic [SHW-1:0]   shift_s   [SHW];
    logic             advance_s;
    logic             busy_s;
`ifdef PBS_FLAGS_EN
    logic             carry_r   [SHW];
    logic             carry_s   [SHW];
    logic             zero_r;
`endif

    // One stage's shift by a fixed amount; mode 11 falls back to logical
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             dir,
        input logic [1:0]       mode,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (mode)
            2'b10: begin
                if (dir) r = (d >> amt) | (d << (WIDTH - amt));
                else     r = (d << amt) | (d >> (WIDTH - amt));
            end
            2'b01: begin
                // arithmetic left is identical to logical left
                if (dir) r = $signed(d) >>> amt;
                else     r = d << amt;
            end
            default: begin
                if (dir) r = d >> amt;
                else     r = d << amt;
            end
        endcase
        return r;
    endfunction

`ifdef PBS_FLAGS_EN
    // Carry produced by one shifting stage; the last shifting stage wins,
    // which equals the last bit shifted out of the original operand
    function automatic logic carry_step(
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] r,
        input logic             dir,
        input logic [1:0]       mode,
        input int               amt
    );
        logic c;
        if (mode == 2'b10) begin
            c = dir ? r[WIDTH-1] : r[0];
        end else begin
            c = dir ? d[amt-1] : d[WIDTH-amt];
        end
        return c;
    endfunction
`endif

    // Whole pipeline moves unless a held result is waiting on downstream
    always_comb begin
        advance_s = !valid_r[SHW-1] || out_ready;
    end

    // Next-state of each stage: take predecessor, apply its 2^k shift if selected
    always_comb begin
        int               prev;
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             src_dir;
        logic [1:0]       src_mode;
        logic [SHW-1:0]   src_shift;
`ifdef PBS_FLAGS_EN
        logic             src_carry;
`endif
        prev      = 0;
        src_valid = 1'b0;
        src_data  = {WIDTH{1'b0}};
        src_dir   = 1'b0;
        src_mode  = 2'b00;
        src_shift = {SHW{1'b0}};
`ifdef PBS_FLAGS_EN
        src_carry = 1'b0;
`endif
        for (int k = 0; k < SHW; k++) begin
            prev = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                src_valid = in_valid;
                src_data  = in_data;
                src_dir   = in_dir;
                src_mode  = in_mode;
                src_shift = in_shift;
`ifdef PBS_FLAGS_EN
                src_carry = 1'b0;
`endif
            end else begin
                src_valid = valid_r[prev];
                src_data  = data_r[prev];
                src_dir   = dir_r[prev];
                src_mode  = mode_r[prev];
                src_shift = shift_r[prev];
`ifdef PBS_FLAGS_EN
                src_carry = carry_r[prev];
`endif
            end
            valid_s[k] = src_valid;
            dir_s[k]   = src_dir;
            mode_s[k]  = src_mode;
            shift_s[k] = src_shift;
            if (src_shift[k]) begin
                data_s[k] = shift_step(src_data, src_dir, src_mode, 32'sd1 << k);
`ifdef PBS_FLAGS_EN
                carry_s[k] = carry_step(src_data, data_s[k], src_dir, src_mode,
                                        32'sd1 << k);
`endif
            end else begin
                data_s[k] = src_data;
`ifdef PBS_FLAGS_EN
                carry_s[k] = src_carry;
`endif
            end
        end
    end

    // Stage registers: cleared by reset, loaded together on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= {WIDTH{1'b0}};
                dir_r[k]   <= 1'b0;
                mode_r[k]  <= 2'b00;
                shift_r[k] <= {SHW{1'b0}};
`ifdef PBS_FLAGS_EN
                carry_r[k] <= 1'b0;
`endif
            end
`ifdef PBS_FLAGS_EN
            zero_r <= 1'b0;
`endif
        end else if (advance_s) begin
            for (int k = 0; k < SHW; k++) begin
                valid_r[k] <= valid_s[k];
                data_r[k]  <= data_s[k];
                dir_r[k]   <= dir_s[k];
                mode_r[k]  <= mode_s[k];
                shift_r[k] <= shift_s[k];
`ifdef PBS_FLAGS_EN
                carry_r[k] <= carry_s[k];
`endif
            end
`ifdef PBS_FLAGS_EN
            zero_r <= (data_s[SHW-1] == {WIDTH{1'b0}});
`endif
        end
    end

    // Activity indicator: any stage holding a live operation
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < SHW; k++) begin
            busy_s = busy_s | valid_r[k];
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_r[SHW-1];
    assign out_data  = data_r[SHW-1];
    assign busy      = busy_s;
`ifdef PBS_FLAGS_EN
    assign out_zero  = zero_r;
    assign out_carry = carry_r[SHW-1];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: an 8-bit and a 32-bit
// instance share clock and reset. Expected results come from a bit-by-bit
// reference model and are queued at handshake time; monitors pop and compare.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid8, in_ready8, in_dir8, out_valid8, out_ready8, busy8;
    logic [7:0]  in_data8, out_data8;
    logic [2:0]  in_shift8;
    logic [1:0]  in_mode8;
    logic        in_valid32, in_ready32, in_dir32, out_valid32, out_ready32, busy32;
    logic [31:0] in_data32, out_data32;
    logic [4:0]  in_shift32;
    logic [1:0]  in_mode32;
`ifdef PBS_FLAGS_EN
    logic        out_zero8, out_carry8, out_zero32, out_carry32;
`endif

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_shift(in_shift8), .in_dir(in_dir8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
`ifdef PBS_FLAGS_EN
        , .out_zero(out_zero8), .out_carry(out_carry8)
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_data(in_data32), .in_shift(in_shift32), .in_dir(in_dir32), .in_mode(in_mode32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32), .busy(busy32)
`ifdef PBS_FLAGS_EN
        , .out_zero(out_zero32), .out_carry(out_carry32)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        carry;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t        q8[$];
    exp_t        q32[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stl8 = 0;
    int          stl32 = 0;
    logic        prev_stall8 = 1'b0;
    logic        prev_stall32 = 1'b0;
    logic [31:0] prev_data8 = 32'd0;
    logic [31:0] prev_data32 = 32'd0;
    bit          done_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: each result bit is picked from the operand position it came from
    function automatic void model(input logic [31:0] d, input int w, input int s,
                                  input logic dir, input logic [1:0] m,
                                  output logic [31:0] r, output logic c);
        int j;
        r = 32'd0;
        for (int i = 0; i < w; i++) begin
            if (!dir) begin
                j = i - s;
                if (j >= 0)       r[i] = d[j];
                else if (m == 2)  r[i] = d[j + w];
                else              r[i] = 1'b0;
            end else begin
                j = i + s;
                if (j < w)        r[i] = d[j];
                else if (m == 2)  r[i] = d[j - w];
                else if (m == 1)  r[i] = d[w - 1];
                else              r[i] = 1'b0;
            end
        end
        c = 1'b0;
        if (s != 0) begin
            if (m == 2) c = dir ? r[w - 1] : r[0];
            else        c = dir ? d[s - 1] : d[w - s];
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit scoreboard: push at accept, pop and compare at retire
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] r;
        logic c;
        if (!rst_n) begin
            q8.delete();
            stl8 = 0;
            prev_stall8 = 1'b0;
        end else begin
            if (in_valid8 && in_ready8) begin
                model({24'd0, in_data8}, 8, int'(in_shift8), in_dir8, in_mode8, r, c);
                e.data = r; e.carry = c; e.cyc = cyc; e.stl = stl8;
                q8.push_back(e);
            end
            if (prev_stall8) chk("hold8", {24'd0, out_data8}, prev_data8);
            chk("in_ready8", {31'd0, in_ready8}, {31'd0, !(out_valid8 && !out_ready8)});
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    chk("unexpected8", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("data8", {24'd0, out_data8}, e.data);
                    chk("lat8", cyc, e.cyc + 3 + stl8 - e.stl);
`ifdef PBS_FLAGS_EN
                    chk("carry8", {31'd0, out_carry8}, {31'd0, e.carry});
                    chk("zero8", {31'd0, out_zero8}, {31'd0, e.data == 32'd0});
`endif
                end
            end
            if (out_valid8 && !out_ready8) stl8++;
            prev_stall8 = out_valid8 && !out_ready8;
            prev_data8 = {24'd0, out_data8};
        end
    end

    // 32-bit scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] r;
        logic c;
        if (!rst_n) begin
            q32.delete();
            stl32 = 0;
            prev_stall32 = 1'b0;
        end else begin
            if (in_valid32 && in_ready32) begin
                model(in_data32, 32, int'(in_shift32), in_dir32, in_mode32, r, c);
                e.data = r; e.carry = c; e.cyc = cyc; e.stl = stl32;
                q32.push_back(e);
            end
            if (prev_stall32) chk("hold32", out_data32, prev_data32);
            if (out_valid32 && out_ready32) begin
                if (q32.size() == 0) begin
                    chk("unexpected32", 32'd1, 32'd0);
                end else begin
                    e = q32.pop_front();
                    chk("data32", out_data32, e.data);
                    chk("lat32", cyc, e.cyc + 5 + stl32 - e.stl);
`ifdef PBS_FLAGS_EN
                    chk("carry32", {31'd0, out_carry32}, {31'd0, e.carry});
                    chk("zero32", {31'd0, out_zero32}, {31'd0, e.data == 32'd0});
`endif
                end
            end
            if (out_valid32 && !out_ready32) stl32++;
            prev_stall32 = out_valid32 && !out_ready32;
            prev_data32 = out_data32;
        end
    end

    task automatic send8(input logic [7:0] d, input logic [2:0] s,
                         input logic dir, input logic [1:0] m);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid8 = 1'b1; in_data8 = d; in_shift8 = s; in_dir8 = dir; in_mode8 = m;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready8;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid8 = 1'b0;
        if (!acc) chk("send8_timeout", 32'd0, 32'd1);
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] s,
                          input logic dir, input logic [1:0] m);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid32 = 1'b1; in_data32 = d; in_shift32 = s; in_dir32 = dir; in_mode32 = m;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid32 = 1'b0;
        if (!acc) chk("send32_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain8", q8.size(), 32'd0);
        chk("drain32", q32.size(), 32'd0);
    endtask

    task automatic reset_state_checks();
        chk("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
        chk("rst_out_data8", {24'd0, out_data8}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_in_ready8", {31'd0, in_ready8}, 32'd1);
        chk("rst_out_valid32", {31'd0, out_valid32}, 32'd0);
        chk("rst_busy32", {31'd0, busy32}, 32'd0);
`ifdef PBS_FLAGS_EN
        chk("rst_zero8", {31'd0, out_zero8}, 32'd0);
        chk("rst_carry8", {31'd0, out_carry8}, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid8 = 1'b0; in_data8 = 8'd0; in_shift8 = 3'd0; in_dir8 = 1'b0; in_mode8 = 2'd0;
        in_valid32 = 1'b0; in_data32 = 32'd0; in_shift32 = 5'd0; in_dir32 = 1'b0; in_mode32 = 2'd0;
        out_ready8 = 1'b1;
        out_ready32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_state_checks();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed cases from the operating rules
        send8(8'h19, 3'd4, 1'b0, 2'b00);
        send8(8'h98, 3'd4, 1'b1, 2'b01);
        send8(8'h98, 3'd7, 1'b1, 2'b00);
        send8(8'h98, 3'd7, 1'b0, 2'b00);
        send8(8'h98, 3'd1, 1'b1, 2'b10);
        send8(8'h81, 3'd1, 1'b0, 2'b10);
        for (int m = 0; m < 4; m++) begin
            send8(8'hA5, 3'd0, m[0], m[1:0]);
        end
        send8(8'hC3, 3'd5, 1'b1, 2'b11);
        drain();

        // back-to-back stream with a 5-cycle downstream stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send8(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready8 = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready8 = 1'b1;
            end
        join
        drain();

        // reset with three operations in flight
        send8(8'h11, 3'd1, 1'b0, 2'b00);
        send8(8'h22, 3'd2, 1'b1, 2'b01);
        send8(8'h33, 3'd3, 1'b0, 2'b10);
        rst_n = 1'b0;
        #1;
        reset_state_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send8(8'h19, 3'd4, 1'b0, 2'b00);
        drain();

        // randomized traffic with input gaps and random back-pressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid8 = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send8(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clk);
                    #1;
                    out_ready8 = ($urandom_range(0, 3) != 0);
                end
                out_ready8 = 1'b1;
            end
        join
        drain();

        // 32-bit sweep of every shift, direction and mode on 0x8000_0001
        for (int s = 0; s < 32; s++) begin
            for (int m = 0; m < 4; m++) begin
                for (int d = 0; d < 2; d++) begin
                    send32(32'h8000_0001, 5'(s), 1'(d), 2'(m));
                end
            end
        end
        drain();

        chk("idle_busy8", {31'd0, busy8}, 32'd0);
        chk("idle_busy32", {31'd0, busy32}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
